// File: rtl/wb_stage.sv
// Writeback stage: selects register-file write data, resolves redirects, and squashes
// the wrong-path slots behind a taken redirect. All outputs are registered.
//
// state  | meaning
// RUN    | normal retirement; a taken branch/jump enters SQUASH
// SQUASH | wrong-path slots dropped for FLUSH_CYCLES cycles; flush held high
module wb_stage #(
    parameter int FLUSH_CYCLES = 3,
    parameter int RD_W         = 6,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       data_mem_in,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       pc_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              n_in,
    input  logic              z_in,
    input  logic              reg_write_in,
    input  logic              memtoreg_in,
    input  logic              pctoreg_in,
    input  logic              branch_neg_in,
    input  logic              branch_z_in,
    input  logic              jump_in,
    input  logic              jump_mem_in,
    output logic              rf_we,
    output logic [RD_W-1:0]   rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              pc_redirect,
    output logic [31:0]       pc_target,
    output logic              flush,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  squashed_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] flush_cnt;

    logic        live;
    logic        taken;
    logic [31:0] wdata_sel;
    logic [31:0] target_sel;

    assign live  = valid_in && (state == RUN);
    // An unconditional jump makes the flag-qualified branch terms irrelevant.
    assign taken = live && (jump_in || jump_mem_in ||
                            (branch_neg_in && n_in) || (branch_z_in && z_in));

    assign wdata_sel  = pctoreg_in  ? pc_in       :
                        memtoreg_in ? data_mem_in : alu_in;
    assign target_sel = jump_mem_in ? data_mem_in : addr_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            flush_cnt    <= '0;
            flush        <= 1'b0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            pc_redirect  <= 1'b0;
            pc_target    <= '0;
            retired_cnt  <= '0;
            squashed_cnt <= '0;
        end else begin
            rf_we       <= live && reg_write_in;
            rf_waddr    <= rd_in;
            rf_wdata    <= wdata_sel;
            pc_redirect <= taken;
            if (taken)
                pc_target <= target_sel;

            if (live && (retired_cnt != {CNT_W{1'b1}}))
                retired_cnt <= retired_cnt + CNT_W'(1);

            case (state)
                RUN: begin
                    if (taken) begin
                        state     <= SQUASH;
                        flush_cnt <= 4'(FLUSH_CYCLES);
                        flush     <= 1'b1;
                    end
                end
                SQUASH: begin
                    if (valid_in && (squashed_cnt != {CNT_W{1'b1}}))
                        squashed_cnt <= squashed_cnt + CNT_W'(1);
                    flush_cnt <= flush_cnt - 4'd1;
                    if (flush_cnt == 4'd1) begin
                        state <= RUN;
                        flush <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule
